// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word handshake and serial stream bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             shift_en;
  logic             ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             last;

  modport master (
    output data_in, load, shift_en,
    input  ready, dout, dout_valid, frame_start, last
  );

  modport slave (
    input  data_in, load, shift_en,
    output ready, dout, dout_valid, frame_start, last
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with gapless word reload
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  piso_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;
  logic             at_last;
  logic             accept;
  logic             out_bit;
  logic             live;

  assign at_last = (cnt == CNT_LAST);
  assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign live    = (state == SHIFT) && bus.shift_en;

  // Ready during the final enabled bit lets the next word follow with no gap.
  assign bus.ready       = (state == IDLE) || (live && at_last);
  assign accept          = bus.load && bus.ready;

  assign bus.dout        = (state == SHIFT) && out_bit;
  assign bus.dout_valid  = live;
  assign bus.frame_start = live && (cnt == '0);
  assign bus.last        = live && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= bus.data_in;
      cnt   <= '0;
    end else if (live) begin
      if (at_last) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        sreg <= shifted;
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer in MSB-first and LSB-first builds
module tb_piso_serializer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Expected stream entries are {dout, frame_start, last}.
  logic [2:0] qa[$];
  logic [2:0] qb[$];

  piso_serializer_if #(.WIDTH(4)) ia ();
  piso_serializer_if #(.WIDTH(4)) ib ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string name);
    @(negedge clk);
    check({name, " ready"}, {7'd0, ia.ready}, 8'd1);
    check({name, " dout"}, {7'd0, ia.dout}, 8'd0);
    check({name, " valid"}, {7'd0, ia.dout_valid}, 8'd0);
  endtask

  always @(negedge clk) begin
    if (ia.dout_valid) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_a: unexpected bit %0b at %0t, expected none", ia.dout, $time);
      end else begin
        check("stream_a", {5'd0, ia.dout, ia.frame_start, ia.last}, {5'd0, qa.pop_front()});
      end
    end
    if (ib.dout_valid) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_b: unexpected bit %0b at %0t, expected none", ib.dout, $time);
      end else begin
        check("stream_b", {5'd0, ib.dout, ib.frame_start, ib.last}, {5'd0, qb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ia.data_in = '0; ia.load = 1'b0; ia.shift_en = 1'b1;
    ib.data_in = '0; ib.load = 1'b0; ib.shift_en = 1'b1;

    #3;
    check("reset ready", {7'd0, ia.ready}, 8'd1);
    check("reset dout", {7'd0, ia.dout}, 8'd0);
    check("reset valid", {7'd0, ia.dout_valid}, 8'd0);
    check("reset frame_start", {7'd0, ia.frame_start}, 8'd0);
    check("reset last", {7'd0, ia.last}, 8'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single word 1011 on both builds: MSB-first 1,0,1,1 and LSB-first 1,1,0,1.
    qa.push_back(3'b110); qa.push_back(3'b000); qa.push_back(3'b100); qa.push_back(3'b101);
    qb.push_back(3'b110); qb.push_back(3'b100); qb.push_back(3'b000); qb.push_back(3'b101);
    ia.load = 1'b1; ia.data_in = 4'b1011;
    ib.load = 1'b1; ib.data_in = 4'b1011;
    tick();
    ia.load = 1'b0; ib.load = 1'b0;
    repeat (4) tick();
    check_idle_a("single idle");
    check("single idle ready_b", {7'd0, ib.ready}, 8'd1);

    // Back-to-back 1011 then 0110 with load held across the reload.
    qa.push_back(3'b110); qa.push_back(3'b000); qa.push_back(3'b100); qa.push_back(3'b101);
    qa.push_back(3'b010); qa.push_back(3'b100); qa.push_back(3'b100); qa.push_back(3'b001);
    tick();
    ia.load = 1'b1; ia.data_in = 4'b1011;
    tick();
    ia.data_in = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b ready word1", {7'd0, ia.ready}, (i == 3) ? 8'd1 : 8'd0);
      tick();
    end
    ia.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b ready word2", {7'd0, ia.ready}, 8'd0);
      tick();
    end
    tick();
    check_idle_a("b2b idle");

    // Stall for 3 cycles with the second bit of 1100 frozen on dout.
    qa.push_back(3'b110); qa.push_back(3'b100); qa.push_back(3'b000); qa.push_back(3'b001);
    ia.load = 1'b1; ia.data_in = 4'b1100;
    tick();
    ia.load = 1'b0;
    tick();
    ia.shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall dout", {7'd0, ia.dout}, 8'd1);
      check("stall valid", {7'd0, ia.dout_valid}, 8'd0);
      check("stall ready", {7'd0, ia.ready}, 8'd0);
      tick();
    end
    ia.shift_en = 1'b1;
    repeat (3) tick();
    check_idle_a("stall idle");

    // Word accepted while shift_en is low waits for the enable.
    qa.push_back(3'b110); qa.push_back(3'b000); qa.push_back(3'b000); qa.push_back(3'b101);
    ia.shift_en = 1'b0;
    ia.load = 1'b1; ia.data_in = 4'b1001;
    tick();
    ia.load = 1'b0;
    @(negedge clk);
    check("preload dout", {7'd0, ia.dout}, 8'd1);
    check("preload frame_start", {7'd0, ia.frame_start}, 8'd0);
    check("preload ready", {7'd0, ia.ready}, 8'd0);
    tick();
    ia.shift_en = 1'b1;
    repeat (4) tick();
    check_idle_a("preload idle");

    // Reset after the second bit of 1111 aborts the word.
    qa.push_back(3'b110); qa.push_back(3'b100);
    ia.load = 1'b1; ia.data_in = 4'b1111;
    tick();
    ia.load = 1'b0;
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort dout", {7'd0, ia.dout}, 8'd0);
    check("abort valid", {7'd0, ia.dout_valid}, 8'd0);
    check("abort frame_start", {7'd0, ia.frame_start}, 8'd0);
    check("abort last", {7'd0, ia.last}, 8'd0);
    check("abort ready", {7'd0, ia.ready}, 8'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    qa.push_back(3'b010); qa.push_back(3'b000); qa.push_back(3'b000); qa.push_back(3'b101);
    ia.load = 1'b1; ia.data_in = 4'b0001;
    tick();
    ia.load = 1'b0;
    repeat (4) tick();
    check_idle_a("post-reset idle");

    // A load pulse while busy is ignored.
    qa.push_back(3'b110); qa.push_back(3'b000); qa.push_back(3'b100); qa.push_back(3'b001);
    ia.load = 1'b1; ia.data_in = 4'b1010;
    tick();
    ia.load = 1'b0;
    tick();
    ia.load = 1'b1; ia.data_in = 4'b0000;
    @(negedge clk);
    check("ignored ready", {7'd0, ia.ready}, 8'd0);
    tick();
    ia.load = 1'b0;
    repeat (2) tick();
    check_idle_a("ignored idle");

    repeat (3) tick();
    check("queue_a drained", 8'(qa.size()), 8'd0);
    check("queue_b drained", 8'(qb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer: the upstream stage that produces the 1-bit serial stream consumed by the sipo register. It accepts a WIDTH-bit word through a LOAD/READY handshake and shifts it out one bit per enabled clock on DOUT. DOUT_VALID, FRAME_START and LAST qualify the stream. Back-to-back words stream with no idle bit between them.

## Interface
- WIDTH, 4: word width in bits; legal values ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- DATA_IN  input  WIDTH  parallel word; sampled only on an accepting edge.
- LOAD  input  1  word-valid request from the producer.
- SHIFT_EN  input  1  shift enable; low freezes the shifter.
- READY  output  1  serializer can accept a word this cycle (combinational).
- DOUT  output  1  current serial bit.
- DOUT_VALID  output  1  DOUT carries a live bit this cycle.
- FRAME_START  output  1  DOUT is the first bit of a word.
- LAST  output  1  DOUT is the final bit of a word.

## Operation
- State: shift register sreg[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits), and a 2-state FSM with states IDLE and SHIFT.
- Reset values (RESET low, applied immediately, independent of CLK):
  - sreg = 0, cnt = 0, state = IDLE.
  - READY = 1, DOUT = 0, DOUT_VALID = 0, FRAME_START = 0, LAST = 0.
- Accept: a word is transferred on a rising edge where LOAD = 1 and READY = 1. On that edge, sreg ← DATA_IN, cnt ← 0, state ← SHIFT.
- READY is 1 in IDLE. In SHIFT, READY is 1 only when cnt = WIDTH-1 and SHIFT_EN = 1 (final-bit reload). It is 0 in all other cases.
- DOUT:
  - In SHIFT: sreg[WIDTH-1] when MSB_FIRST = 1, else sreg[0].
  - In IDLE: forced to 0.
- Status outputs:
  - DOUT_VALID = (state = SHIFT) & SHIFT_EN.
  - FRAME_START = DOUT_VALID & (cnt = 0).
  - LAST = DOUT_VALID & (cnt = WIDTH-1).
- IDLE → SHIFT: on an accepting edge.
- SHIFT with SHIFT_EN = 1, cnt < WIDTH-1:
  - sreg shifts toward the output end (left if MSB_FIRST, else right) and zero-fills the vacated bit.
  - cnt increments.
- SHIFT with SHIFT_EN = 1, cnt = WIDTH-1:
  - LOAD = 1: reload sreg from DATA_IN, cnt ← 0, stay in SHIFT (gapless).
  - LOAD = 0: go to IDLE, sreg ← 0, cnt ← 0.
- SHIFT with SHIFT_EN = 0: sreg, cnt and state hold. DOUT holds its value. DOUT_VALID, FRAME_START and LAST are 0.
- SHIFT_EN is ignored in IDLE. A word can be accepted while SHIFT_EN = 0; its first bit is presented when SHIFT_EN next goes high.
- LOAD while READY = 0: the request is ignored and DATA_IN is not sampled. The producer must hold LOAD and DATA_IN until it sees READY.
- Reset mid-word: the word is aborted and all outputs return to reset values. No partial word resumes after reset is released.

## Timing
- Accept on edge k: the first bit is on DOUT during cycle k+1, with FRAME_START = 1 if SHIFT_EN = 1.
- With SHIFT_EN held high, the last bit is on DOUT during cycle k+WIDTH, with LAST = 1.
- Throughput: one word per WIDTH enabled cycles. There is no dead cycle between reloaded words.
- READY depends combinationally on state, cnt and SHIFT_EN only. It has no path from LOAD or DATA_IN.
- RESET release: the first accepting edge is the first rising edge with RESET = 1.

## Test plan
- Single word, WIDTH=4, MSB_FIRST=1, SHIFT_EN=1:
  - Stimulus: LOAD with DATA_IN=4'b1011 for one cycle.
  - Required: DOUT = 1,0,1,1 on the next 4 cycles, with DOUT_VALID high throughout.
  - Required: FRAME_START only on the first of those cycles and LAST only on the fourth.
  - Required: then IDLE with DOUT = 0 and READY = 1.
- Back-to-back words:
  - Stimulus: 4'b1011 then 4'b0110, with LOAD held across the reload.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0.
  - Required: READY high only in IDLE and in the LAST cycle of the first word.
  - Required: FRAME_START on bits 1 and 5.
- Stall:
  - Stimulus: load 4'b1100, then drop SHIFT_EN for 3 cycles after the second bit.
  - Required: DOUT holds 1 and DOUT_VALID is 0 during the stall; cnt is unchanged.
  - Required: after the stall, bits 0,0 follow with LAST on the final 0.
- LSB-first:
  - Stimulus: MSB_FIRST=0, load 4'b1011.
  - Required: DOUT = 1,1,0,1.
- Reset mid-word:
  - Stimulus: assert RESET low after the second bit of 4'b1111.
  - Required: DOUT, DOUT_VALID, FRAME_START and LAST go to 0 immediately; READY = 1.
  - Required: after release, a new load of 4'b0001 emits 0,0,0,1 with no residual bits.
- Ignored load:
  - Stimulus: pulse LOAD with DATA_IN=4'b0000 while the second bit of 4'b1010 is on DOUT.
  - Required: the stream stays 1,0,1,0, then returns to IDLE.
